// File: rtl/pipe_hazard_ctrl_if.sv
// Control bundle between the pipeline sequencer and the 5-stage datapath.
// The slave side is the sequencer; the master side is the datapath.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             ihit;
    logic             dhit;
    logic             mem_dren;
    logic             mem_dwen;
    logic             ex_dren;
    logic [4:0]       ex_wsel;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             ex_brtaken;
    logic             id_jump;
    logic             ex_halt;
    logic             pc_W;
    logic             ifid_W;
    logic             ifid_RST;
    logic             idex_W;
    logic             idex_RST;
    logic             exmem_W;
    logic             exmem_RST;
    logic             memwb_W;
    logic             memwb_RST;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;

    modport slave (
        input  ihit, dhit, mem_dren, mem_dwen, ex_dren, ex_wsel, id_rs, id_rt,
               id_uses_rt, ex_brtaken, id_jump, ex_halt,
        output pc_W, ifid_W, ifid_RST, idex_W, idex_RST, exmem_W, exmem_RST,
               memwb_W, memwb_RST, halted, stall_cnt
    );

    modport master (
        output ihit, dhit, mem_dren, mem_dwen, ex_dren, ex_wsel, id_rs, id_rt,
               id_uses_rt, ex_brtaken, id_jump, ex_halt,
        input  pc_W, ifid_W, ifid_RST, idex_W, idex_RST, exmem_W, exmem_RST,
               memwb_W, memwb_RST, halted, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: stage write-enables/flushes, PC enable, HALT drain
// and a saturating stall counter for the 5-stage core.
module pipe_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             CLK,
    input  logic             RST,
    pipe_hazard_ctrl_if.slave hz
);
    localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_HALTED
    } state_t;

    state_t           state_reg;
    logic [DW-1:0]    drain_cnt_reg;
    logic             halted_reg;
    logic [CNT_W-1:0] stall_cnt_reg;

    logic pc_w, ifid_w, ifid_rst, idex_w, idex_rst;
    logic exmem_w, exmem_rst, memwb_w, memwb_rst;
    logic dmem_wait, load_use;

    assign dmem_wait = (hz.mem_dren | hz.mem_dwen) & ~hz.dhit;
    assign load_use  = hz.ex_dren && (hz.ex_wsel != 5'd0) &&
                       ((hz.ex_wsel == hz.id_rs) ||
                        (hz.id_uses_rt && (hz.ex_wsel == hz.id_rt)));

    always_comb begin
        pc_w      = 1'b0;
        ifid_w    = 1'b0;
        ifid_rst  = 1'b0;
        idex_w    = 1'b0;
        idex_rst  = 1'b0;
        exmem_w   = 1'b0;
        exmem_rst = 1'b0;
        memwb_w   = 1'b0;
        memwb_rst = 1'b0;
        if (RST) begin
            ifid_rst  = 1'b1;
            idex_rst  = 1'b1;
            exmem_rst = 1'b1;
            memwb_rst = 1'b1;
        end else begin
            case (state_reg)
                S_RUN: begin
                    if (!dmem_wait) begin
                        // Back half always advances once data memory is ready.
                        idex_w  = 1'b1;
                        exmem_w = 1'b1;
                        memwb_w = 1'b1;
                        if (!hz.ihit) begin
                            idex_rst = 1'b1;
                        end else if (hz.ex_brtaken) begin
                            pc_w     = 1'b1;
                            ifid_w   = 1'b1;
                            ifid_rst = 1'b1;
                            idex_rst = 1'b1;
                        end else if (load_use) begin
                            idex_rst = 1'b1;
                        end else if (hz.id_jump) begin
                            pc_w     = 1'b1;
                            ifid_w   = 1'b1;
                            ifid_rst = 1'b1;
                        end else begin
                            pc_w   = 1'b1;
                            ifid_w = 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    // Front end keeps bubbling; only MEM and WB finish work.
                    ifid_w   = 1'b1;
                    ifid_rst = 1'b1;
                    idex_w   = 1'b1;
                    idex_rst = 1'b1;
                    exmem_w  = ~dmem_wait;
                    memwb_w  = ~dmem_wait;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg     <= S_RUN;
            drain_cnt_reg <= '0;
            halted_reg    <= 1'b0;
            stall_cnt_reg <= '0;
        end else begin
            case (state_reg)
                S_RUN: begin
                    if (!pc_w && (stall_cnt_reg != {CNT_W{1'b1}}))
                        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
                    if (hz.ex_halt && exmem_w) begin
                        state_reg     <= S_DRAIN;
                        drain_cnt_reg <= DW'(DRAIN_CYCLES);
                    end
                end
                S_DRAIN: begin
                    // Halted goes high on the same edge the state enters HALTED.
                    if (drain_cnt_reg == '0) begin
                        state_reg  <= S_HALTED;
                        halted_reg <= 1'b1;
                    end else if (memwb_w) begin
                        drain_cnt_reg <= drain_cnt_reg - DW'(1);
                        if (drain_cnt_reg == DW'(1)) begin
                            state_reg  <= S_HALTED;
                            halted_reg <= 1'b1;
                        end
                    end
                end
                S_HALTED: halted_reg <= 1'b1;
                default:  state_reg  <= S_RUN;
            endcase
        end
    end

    assign hz.pc_W      = pc_w;
    assign hz.ifid_W    = ifid_w;
    assign hz.ifid_RST  = ifid_rst;
    assign hz.idex_W    = idex_w;
    assign hz.idex_RST  = idex_rst;
    assign hz.exmem_W   = exmem_w;
    assign hz.exmem_RST = exmem_rst;
    assign hz.memwb_W   = memwb_w;
    assign hz.memwb_RST = memwb_rst;
    assign hz.halted    = halted_reg;
    assign hz.stall_cnt = stall_cnt_reg;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hazards, memory waits, HALT drain, reset abort.
module tb_pipe_hazard_ctrl;
    logic CLK;
    logic RST;
    int   chk_cnt;
    int   err_cnt;

    pipe_hazard_ctrl_if #(.CNT_W(16)) hz ();

    pipe_hazard_ctrl #(
        .DRAIN_CYCLES(2),
        .CNT_W       (16)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .hz (hz.slave)
    );

    // {pc_W, ifid_W, ifid_RST, idex_W, idex_RST, exmem_W, exmem_RST, memwb_W, memwb_RST}
    logic [8:0] ctrl;
    assign ctrl = {hz.pc_W, hz.ifid_W, hz.ifid_RST, hz.idex_W, hz.idex_RST,
                   hz.exmem_W, hz.exmem_RST, hz.memwb_W, hz.memwb_RST};

    localparam logic [8:0] C_ALLW   = 9'b110101010;
    localparam logic [8:0] C_RESET  = 9'b001010101;
    localparam logic [8:0] C_NONE   = 9'b000000000;
    localparam logic [8:0] C_BUBBLE = 9'b000111010;
    localparam logic [8:0] C_BRANCH = 9'b111111010;
    localparam logic [8:0] C_JUMP   = 9'b111101010;
    localparam logic [8:0] C_DRAIN  = 9'b011111010;
    localparam logic [8:0] C_DRWAIT = 9'b011110000;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle;
        hz.ihit       = 1'b1;
        hz.dhit       = 1'b1;
        hz.mem_dren   = 1'b0;
        hz.mem_dwen   = 1'b0;
        hz.ex_dren    = 1'b0;
        hz.ex_wsel    = 5'd0;
        hz.id_rs      = 5'd0;
        hz.id_rt      = 5'd0;
        hz.id_uses_rt = 1'b0;
        hz.ex_brtaken = 1'b0;
        hz.id_jump    = 1'b0;
        hz.ex_halt    = 1'b0;
    endtask

    // Inputs already applied at posedge+1; let them settle, then compare.
    task automatic cyc(input string tag, input logic [8:0] exp_ctrl);
        #3;
        check(tag, 32'(ctrl), 32'(exp_ctrl));
        $display("cycle %0t %s ctrl=%b halted=%0d stall_cnt=%0d", $time, tag, ctrl, hz.halted, hz.stall_cnt);
        tick();
    endtask

    task automatic do_reset;
        RST = 1'b1;
        idle();
        tick();
        RST = 1'b0;
    endtask

    initial begin
        chk_cnt = 0;
        err_cnt = 0;
        RST = 1'b1;
        idle();
        #1;
        check("reset_ctrl_async_view", 32'(ctrl), 32'(C_RESET));
        tick();
        cyc("reset_ctrl", C_RESET);
        RST = 1'b0;
        #3;
        check("post_reset_halted", 32'(hz.halted), 32'd0);
        check("post_reset_stall", 32'(hz.stall_cnt), 32'd0);
        #0;
        cyc("post_reset_run", C_ALLW);

        // Load-use on rs
        hz.ex_dren = 1'b1; hz.ex_wsel = 5'd5; hz.id_rs = 5'd5;
        cyc("loaduse_rs", C_BUBBLE);
        idle();
        check("stall_after_loaduse", 32'(hz.stall_cnt), 32'd1);
        cyc("after_loaduse", C_ALLW);
        // r0 destination never stalls
        hz.ex_dren = 1'b1; hz.ex_wsel = 5'd0; hz.id_rs = 5'd0;
        cyc("loaduse_r0", C_ALLW);
        // rt match only counts when rt is read
        hz.ex_dren = 1'b1; hz.ex_wsel = 5'd7; hz.id_rs = 5'd3; hz.id_rt = 5'd7;
        cyc("rt_unused", C_ALLW);
        hz.ex_dren = 1'b1; hz.ex_wsel = 5'd7; hz.id_rs = 5'd3; hz.id_rt = 5'd7; hz.id_uses_rt = 1'b1;
        cyc("loaduse_rt", C_BUBBLE);
        idle();
        check("stall_after_rt", 32'(hz.stall_cnt), 32'd2);
        // imem wait
        hz.ihit = 1'b0;
        cyc("imem_wait", C_BUBBLE);
        idle();
        hz.id_jump = 1'b1;
        cyc("jump", C_JUMP);
        idle();
        check("stall_after_imem", 32'(hz.stall_cnt), 32'd3);

        // dmem wait for 3 cycles, with ihit=0 on one of them (ignored)
        hz.mem_dren = 1'b1; hz.dhit = 1'b0;
        cyc("dwait1", C_NONE);
        hz.ihit = 1'b0;
        cyc("dwait2", C_NONE);
        hz.ihit = 1'b1;
        cyc("dwait3", C_NONE);
        hz.dhit = 1'b1;
        cyc("dwait_done", C_ALLW);
        idle();
        check("stall_after_dwait", 32'(hz.stall_cnt), 32'd6);

        // Branch beats load-use
        hz.ex_brtaken = 1'b1; hz.ex_dren = 1'b1; hz.ex_wsel = 5'd9; hz.id_rs = 5'd9;
        cyc("branch_over_loaduse", C_BRANCH);
        idle();
        check("stall_after_branch", 32'(hz.stall_cnt), 32'd6);

        // HALT drain: halted three cycles after ex_halt
        hz.ex_halt = 1'b1;
        cyc("halt_in_ex", C_ALLW);
        idle();
        cyc("drain1", C_DRAIN);
        check("halted_drain2", 32'(hz.halted), 32'd0);
        cyc("drain2", C_DRAIN);
        check("halted_set", 32'(hz.halted), 32'd1);
        hz.ex_brtaken = 1'b1; hz.id_jump = 1'b1;
        cyc("halted_quiet", C_NONE);
        idle();
        cyc("halted_quiet2", C_NONE);
        check("halted_sticky", 32'(hz.halted), 32'd1);
        check("stall_frozen_outside_run", 32'(hz.stall_cnt), 32'd6);

        // Drain delayed by a data-memory wait
        do_reset();
        check("reset2_halted", 32'(hz.halted), 32'd0);
        check("reset2_stall", 32'(hz.stall_cnt), 32'd0);
        hz.ex_halt = 1'b1;
        cyc("halt2_in_ex", C_ALLW);
        idle();
        hz.mem_dwen = 1'b1; hz.dhit = 1'b0;
        cyc("drain_wait1", C_DRWAIT);
        cyc("drain_wait2", C_DRWAIT);
        idle();
        cyc("drain_late1", C_DRAIN);
        check("halted_late_not_yet", 32'(hz.halted), 32'd0);
        cyc("drain_late2", C_DRAIN);
        check("halted_late", 32'(hz.halted), 32'd1);
        cyc("halted_late_quiet", C_NONE);

        // Reset in the middle of a drain returns to RUN
        do_reset();
        hz.ex_halt = 1'b1;
        cyc("halt3_in_ex", C_ALLW);
        idle();
        cyc("drain3", C_DRAIN);
        RST = 1'b1;
        cyc("reset_mid_drain", C_RESET);
        RST = 1'b0;
        cyc("run_after_abort", C_ALLW);
        cyc("run_after_abort2", C_ALLW);
        cyc("run_after_abort3", C_ALLW);
        check("halted_after_abort", 32'(hz.halted), 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
